// File: rtl/branch_tracker_pkg.sv
// Shared types and sizing for the branch tracker.
// Record layout: branch PC plus predicted direction.
package branch_tracker_pkg;

  localparam int XLEN = 32;
  localparam int BT_DEPTH = 8;
  localparam int BT_REC_W = XLEN + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            pred;
  } bt_rec_t;

endpackage

// File: rtl/bt_fifo.sv
// Generic circular FIFO with push, pop and flush.
// Flush keeps the post-pop head and empties the queue.
module bt_fifo #(
  parameter int DW = 8,
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [DW-1:0]    push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [DW-1:0]    pop_data_o,
  output logic             pop_ok_o,
  output logic [PTR_W:0]   count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [DW-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic push_ok;
  logic pop_ok;

  assign full_o     = count_q == (PTR_W+1)'(DEPTH);
  assign empty_o    = count_q == '0;
  assign push_ok    = push_i & ~full_o & ~flush_i;
  assign pop_ok     = pop_i & ~empty_o;
  assign pop_ok_o   = pop_ok;
  assign pop_data_o = mem_q[head_q];
  assign count_o    = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_ok) head_d = head_q + PTR_W'(1);
    if (push_ok) tail_d = tail_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A flush collapses the queue onto the post-commit head.
    if (flush_i) begin
      tail_d  = head_d;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[tail_q] <= push_data_i;
  end

endmodule

// File: rtl/branch_tracker.sv
// Pairs fetched branch predictions with commit outcomes
// and drives one predictor-update strobe per committed branch.
module branch_tracker
  import branch_tracker_pkg::*;
#(
  parameter int DEPTH = BT_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fet_br_valid,
  input  logic [XLEN-1:0] fet_br_pc,
  input  logic            fet_br_pred,
  input  logic            rob_br_commit,
  input  logic            rob_br_jump,
  input  logic            rob_flush,
  output logic            bt_full,
  output logic [PTR_W:0]  bt_count,
  output logic            bt_bp_enable,
  output logic [XLEN-1:0] bt_bp_inst_addr,
  output logic            bt_bp_jump,
  output logic            bt_bp_correct,
  output logic            bt_overflow,
  output logic            bt_underflow
);

  bt_rec_t push_rec;
  bt_rec_t head_rec;
  logic    commit_ok;
  logic    empty;

  logic            en_q, en_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            jump_q, jump_d;
  logic            corr_q, corr_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;

  assign push_rec = '{pc: fet_br_pc, pred: fet_br_pred};

  bt_fifo #(
    .DW    (BT_REC_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (fet_br_valid),
    .push_data_i (push_rec),
    .pop_i       (rob_br_commit),
    .flush_i     (rob_flush),
    .pop_data_o  (head_rec),
    .pop_ok_o    (commit_ok),
    .count_o     (bt_count),
    .full_o      (bt_full),
    .empty_o     (empty)
  );

  always_comb begin
    en_d   = commit_ok;
    addr_d = addr_q;
    jump_d = jump_q;
    corr_d = corr_q;
    if (commit_ok) begin
      addr_d = head_rec.pc;
      jump_d = rob_br_jump;
      corr_d = head_rec.pred == rob_br_jump;
    end
    // A flush-dropped allocation is not an overflow.
    ovf_d = ovf_q | (fet_br_valid & bt_full & ~rob_flush);
    udf_d = udf_q | (rob_br_commit & empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      addr_q <= '0;
      jump_q <= 1'b0;
      corr_q <= 1'b0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      en_q   <= en_d;
      addr_q <= addr_d;
      jump_q <= jump_d;
      corr_q <= corr_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  assign bt_bp_enable    = en_q;
  assign bt_bp_inst_addr = addr_q;
  assign bt_bp_jump      = jump_q;
  assign bt_bp_correct   = corr_q;
  assign bt_overflow     = ovf_q;
  assign bt_underflow    = udf_q;

endmodule

// File: doc/branch_tracker.md
# branch_tracker

Tracks every in-flight conditional branch between fetch and commit. At fetch it records the branch PC and the predicted direction. At ROB commit it pairs that record with the resolved outcome. It then drives the branch predictor's update port (enable, instruction address, jump, correct) for exactly one cycle per committed branch. It sits between the Fetcher, the ROB and the branch predictor, and is the writer side of the predictor-update interface.

## Interface
- `DEPTH`, default 8: tracked-branch capacity; power of two, ≥2.
- `PTR_W`, default `$clog2(DEPTH)`: pointer width; derived, not overridden.
- `clk` input 1: system clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `fet_br_valid` input 1: Fetcher issues a conditional branch this cycle.
- `fet_br_pc` input `XLEN`: address of that branch.
- `fet_br_pred` input 1: predicted direction, 1 = taken.
- `rob_br_commit` input 1: ROB commits the oldest conditional branch this cycle.
- `rob_br_jump` input 1: resolved direction of the committing branch.
- `rob_flush` input 1: pipeline flush; discards all uncommitted records.
- `bt_full` output 1: count == DEPTH; Fetcher must stall branch issue.
- `bt_count` output PTR_W+1: number of valid records.
- `bt_bp_enable` output 1: predictor update strobe.
- `bt_bp_inst_addr` output `XLEN`: PC of the updated branch.
- `bt_bp_jump` output 1: resolved direction.
- `bt_bp_correct` output 1: prediction matched the outcome.
- `bt_overflow` output 1: sticky; an allocation was attempted while full.
- `bt_underflow` output 1: sticky; a commit was attempted while empty.

## Operation
- Circular FIFO of {pc, pred}, with `head` (oldest), `tail` (next free) and `count`. Pointers wrap modulo DEPTH.
- Allocate: `fet_br_valid` and not full and not `rob_flush` → write at `tail`, tail+1, count+1.
- Commit: `rob_br_commit` and count>0 → read `head`; register update outputs; head+1, count−1.
  - `bt_bp_inst_addr` = head.pc.
  - `bt_bp_jump` = `rob_br_jump`.
  - `bt_bp_correct` = (head.pred == `rob_br_jump`).
- Allocate and commit in the same cycle, neither blocked: both occur; count unchanged.
- Allocate while full: dropped and `bt_overflow` set, even if a commit frees a slot that cycle. `bt_full` is based on count before the edge.
- Commit while empty: ignored, no update strobe, `bt_underflow` set. There is no bypass of a same-cycle allocation.
- Flush:
  - A commit in the same cycle is processed first, and its update is still emitted.
  - Then head = tail = pos, count = 0, where pos is the post-commit head.
  - Any same-cycle allocation is dropped. This is not an overflow.
- Sticky flags clear only on reset.
- Reset values: all outputs 0; head = tail = count = 0; storage contents are don't-care.
- Reset asserted mid-operation clears all state immediately. A pending update strobe is cancelled.

## Timing
- Update latency is 1 cycle. A commit sampled at edge N gives `bt_bp_enable` = 1 during cycle N→N+1, with address, jump and correct stable alongside it.
- `bt_bp_enable` is high for exactly one cycle per accepted commit. Back-to-back commits give back-to-back strobes.
- `bt_bp_inst_addr`, `bt_bp_jump` and `bt_bp_correct` hold their last values while `bt_bp_enable` is 0.
- `bt_full` and `bt_count` are registered-state derived, so an allocation at edge N is reflected in cycle N+1.
- No combinational path from `rob_*` inputs to the `bt_bp_*` outputs.
- Storage holds DEPTH×(XLEN+1) bits; a flop array is sufficient.

## Structure
- `global_params.v` supplies `XLEN`.
- Add `BT_DEPTH` to `global_params.v`, default 8.
- The record-width constant lives alongside `BT_DEPTH`.
- One natural sub-module: `bt_fifo`, a generic circular FIFO. It takes a data-width parameter and provides push, pop and flush ports plus count. `branch_tracker` adds the correctness compare, update register and sticky flags.

## Test plan
- Reset → all outputs 0.
- Allocate PC `0x100` pred=1, then commit jump=1 → next cycle: enable=1, addr=`0x100`, jump=1, correct=1; count back to 0.
- Allocate 8 branches with pred=0 (PCs `0x200`–`0x21C`) → `bt_full`=1.
  - A 9th allocation sets `bt_overflow`; count stays 8.
  - 8 commits with jump=1 give 8 consecutive strobes, in order, all correct=0.
- Full FIFO, simultaneous allocate and commit → allocation dropped, `bt_overflow`=1, count=7.
- Count=3, commit and `rob_flush` in the same cycle → one strobe for the oldest PC, then count=0; the next allocation lands at the post-commit head.
- Commit while empty → no strobe, `bt_underflow`=1.
- `rst_n` low during a strobe cycle → strobe drops immediately; flags and count are 0.
